// File: rtl/fifo_status_monitor.sv
// rtl/fifo_status_monitor.sv - occupancy tracking and status flags for the five datapath FIFOs
module fifo_status_monitor #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         push,
    input  logic [4:0]         pop,
    input  logic               cfg_load,
    input  logic [5*CNT_W-1:0] af_th_i,
    input  logic [5*CNT_W-1:0] ae_th_i,
    input  logic               err_clr,
    output logic [4:0]         FIFO_empties,
    output logic [4:0]         FIFO_errors,
    output logic [4:0]         almost_full,
    output logic [4:0]         almost_empty,
    output logic               all_empty,
    output logic               cfg_err
);

    localparam int NF = 5;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_RST  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] AE_RST  = CNT_W'(1);

    logic [NF-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NF-1:0][CNT_W-1:0] af_th_q, af_th_d;
    logic [NF-1:0][CNT_W-1:0] ae_th_q, ae_th_d;
    logic [NF-1:0]            err_q, err_d, new_err;
    logic [NF-1:0]            empty_q, empty_d;
    logic [NF-1:0]            af_q, af_d;
    logic [NF-1:0]            ae_q, ae_d;
    logic                     cfg_err_q, cfg_err_d;
    logic                     load_ok;

    always_comb begin
        // Thresholds may only change while nothing is queued or arriving.
        load_ok   = (&empty_q) && (push == '0);
        af_th_d   = af_th_q;
        ae_th_d   = ae_th_q;
        if (cfg_load && load_ok) begin
            af_th_d = af_th_i;
            ae_th_d = ae_th_i;
        end
        cfg_err_d = (cfg_err_q & ~err_clr) | (cfg_load & ~load_ok);

        cnt_d   = cnt_q;
        new_err = '0;
        empty_d = '0;
        af_d    = '0;
        ae_d    = '0;
        for (int i = 0; i < NF; i++) begin
            case ({push[i], pop[i]})
                2'b10: begin
                    if (cnt_q[i] == DEPTH_C) new_err[i] = 1'b1;
                    else                     cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                end
                2'b01: begin
                    if (cnt_q[i] == '0) new_err[i] = 1'b1;
                    else                cnt_d[i]   = cnt_q[i] - CNT_W'(1);
                end
                2'b11: begin
                    // The pop misses the entry being pushed, so the push still lands.
                    if (cnt_q[i] == '0) begin
                        cnt_d[i]   = CNT_W'(1);
                        new_err[i] = 1'b1;
                    end
                end
                default: ;
            endcase
            empty_d[i] = (cnt_d[i] == '0);
            af_d[i]    = (af_th_d[i] != '0) && (cnt_d[i] >= af_th_d[i]);
            ae_d[i]    = (cnt_d[i] <= ae_th_d[i]);
        end
        err_d = (err_clr ? '0 : err_q) | new_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            af_th_q   <= {NF{AF_RST}};
            ae_th_q   <= {NF{AE_RST}};
            err_q     <= '0;
            cfg_err_q <= 1'b0;
            empty_q   <= '1;
            af_q      <= '0;
            ae_q      <= '1;
        end else begin
            cnt_q     <= cnt_d;
            af_th_q   <= af_th_d;
            ae_th_q   <= ae_th_d;
            err_q     <= err_d;
            cfg_err_q <= cfg_err_d;
            empty_q   <= empty_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
        end
    end

    assign FIFO_empties = empty_q;
    assign FIFO_errors  = err_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign all_empty    = &empty_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_fifo_status_monitor.sv
// tb/tb_fifo_status_monitor.sv - directed vector table plus randomized run against a reference model
module tb_fifo_status_monitor;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int NF    = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic [4:0]         push, pop;
    logic               cfg_load;
    logic [5*CNT_W-1:0] af_th_i, ae_th_i;
    logic               err_clr;
    logic [4:0]         FIFO_empties, FIFO_errors, almost_full, almost_empty;
    logic               all_empty, cfg_err;

    always #5 clk = ~clk;

    fifo_status_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .cfg_load(cfg_load),
        .af_th_i(af_th_i), .ae_th_i(ae_th_i), .err_clr(err_clr),
        .FIFO_empties(FIFO_empties), .FIFO_errors(FIFO_errors),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .all_empty(all_empty), .cfg_err(cfg_err)
    );

    typedef struct {
        logic         rst;
        logic [4:0]   psh, pp;
        logic         ld;
        logic [14:0]  af, ae;
        logic         clr;
        logic [4:0]   e_emp, e_err, e_af, e_ae;
        logic         e_cerr;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int       m_cnt[NF], m_af[NF], m_ae[NF];
    bit [4:0] m_err;
    bit       m_cerr;

    function automatic logic [14:0] rep(int v);
        logic [14:0] r;
        for (int i = 0; i < NF; i++) r[i*CNT_W +: CNT_W] = 3'(v);
        return r;
    endfunction

    function automatic void add(logic rst, logic [4:0] psh, logic [4:0] pp, logic ld,
                                logic [14:0] af, logic [14:0] ae, logic clr,
                                logic [4:0] e_emp, logic [4:0] e_err, logic [4:0] e_af,
                                logic [4:0] e_ae, logic e_cerr);
        vec_t v;
        v.rst = rst; v.psh = psh; v.pp = pp; v.ld = ld; v.af = af; v.ae = ae; v.clr = clr;
        v.e_emp = e_emp; v.e_err = e_err; v.e_af = e_af; v.e_ae = e_ae; v.e_cerr = e_cerr;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, int idx, logic [4:0] act, logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic [4:0] psh, logic [4:0] pp, logic ld,
                         logic [14:0] af, logic [14:0] ae, logic clr);
        @(negedge clk);
        reset = rst; push = psh; pop = pp; cfg_load = ld;
        af_th_i = af; ae_th_i = ae; err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    // Reference: occupancy as plain integers, updated from the strobe rules.
    function automatic void model_step(logic rst, logic [4:0] psh, logic [4:0] pp, logic ld,
                                       logic [14:0] af, logic [14:0] ae, logic clr);
        bit       all_zero;
        bit [4:0] ne;
        if (rst) begin
            for (int i = 0; i < NF; i++) begin
                m_cnt[i] = 0; m_af[i] = DEPTH - 1; m_ae[i] = 1;
            end
            m_err = '0; m_cerr = 0;
            return;
        end
        all_zero = 1;
        for (int i = 0; i < NF; i++) if (m_cnt[i] != 0) all_zero = 0;
        ne = '0;
        for (int i = 0; i < NF; i++) begin
            if (psh[i] && !pp[i]) begin
                if (m_cnt[i] < DEPTH) m_cnt[i]++; else ne[i] = 1;
            end else if (pp[i] && !psh[i]) begin
                if (m_cnt[i] > 0) m_cnt[i]--; else ne[i] = 1;
            end else if (pp[i] && psh[i] && m_cnt[i] == 0) begin
                m_cnt[i] = 1; ne[i] = 1;
            end
        end
        m_err  = (clr ? 5'h0 : m_err) | ne;
        m_cerr = (clr ? 1'b0 : m_cerr) | (ld && !(all_zero && psh == 0));
        if (ld && all_zero && psh == 0)
            for (int i = 0; i < NF; i++) begin
                m_af[i] = int'(af[i*CNT_W +: CNT_W]);
                m_ae[i] = int'(ae[i*CNT_W +: CNT_W]);
            end
    endfunction

    initial begin
        logic [14:0] a2, z0, z;
        logic [4:0]  e_emp, e_af, e_ae;
        a2 = rep(2); z0 = rep(0); z = '0;
        reset = 1; push = 0; pop = 0; cfg_load = 0; af_th_i = 0; ae_th_i = 0; err_clr = 0;

        // rst psh   pp    ld af  ae  clr | emp   err   af    ae    cerr
        add(1, 5'h1F, 5'h00, 0, z, z, 0,    5'h1F, 5'h00, 5'h00, 5'h1F, 0);
        add(1, 5'h1F, 5'h00, 0, z, z, 0,    5'h1F, 5'h00, 5'h00, 5'h1F, 0);
        add(0, 5'h01, 5'h00, 0, z, z, 0,    5'h1E, 5'h00, 5'h00, 5'h1F, 0);
        add(0, 5'h01, 5'h00, 0, z, z, 0,    5'h1E, 5'h00, 5'h00, 5'h1E, 0);
        add(0, 5'h01, 5'h00, 0, z, z, 0,    5'h1E, 5'h00, 5'h01, 5'h1E, 0);
        add(0, 5'h01, 5'h00, 0, z, z, 0,    5'h1E, 5'h00, 5'h01, 5'h1E, 0);
        add(0, 5'h01, 5'h00, 0, z, z, 0,    5'h1E, 5'h01, 5'h01, 5'h1E, 0);
        add(0, 5'h00, 5'h00, 0, z, z, 1,    5'h1E, 5'h00, 5'h01, 5'h1E, 0);
        add(0, 5'h00, 5'h01, 0, z, z, 0,    5'h1E, 5'h00, 5'h01, 5'h1E, 0);
        add(0, 5'h00, 5'h01, 0, z, z, 0,    5'h1E, 5'h00, 5'h00, 5'h1E, 0);
        add(0, 5'h00, 5'h01, 0, z, z, 0,    5'h1E, 5'h00, 5'h00, 5'h1F, 0);
        add(0, 5'h00, 5'h01, 0, z, z, 0,    5'h1F, 5'h00, 5'h00, 5'h1F, 0);
        add(0, 5'h00, 5'h04, 0, z, z, 0,    5'h1F, 5'h04, 5'h00, 5'h1F, 0);
        add(0, 5'h08, 5'h08, 0, z, z, 0,    5'h17, 5'h0C, 5'h00, 5'h1F, 0);
        add(0, 5'h00, 5'h00, 0, z, z, 1,    5'h17, 5'h00, 5'h00, 5'h1F, 0);
        add(0, 5'h00, 5'h08, 0, z, z, 0,    5'h1F, 5'h00, 5'h00, 5'h1F, 0);
        add(0, 5'h00, 5'h01, 0, z, z, 1,    5'h1F, 5'h01, 5'h00, 5'h1F, 0);
        add(0, 5'h00, 5'h00, 0, z, z, 1,    5'h1F, 5'h00, 5'h00, 5'h1F, 0);
        for (int k = 0; k < 4; k++)
            add(0, 5'h02, 5'h00, 0, z, z, 0, 5'h1D, 5'h00, (k >= 2) ? 5'h02 : 5'h00,
                (k == 0) ? 5'h1F : 5'h1D, 0);
        for (int k = 0; k < 3; k++)
            add(0, 5'h02, 5'h02, 0, z, z, 0, 5'h1D, 5'h00, 5'h02, 5'h1D, 0);
        add(0, 5'h00, 5'h02, 0, z, z, 0,    5'h1D, 5'h00, 5'h02, 5'h1D, 0);
        add(0, 5'h00, 5'h02, 0, z, z, 0,    5'h1D, 5'h00, 5'h00, 5'h1D, 0);
        add(0, 5'h00, 5'h02, 0, z, z, 0,    5'h1D, 5'h00, 5'h00, 5'h1F, 0);
        add(0, 5'h00, 5'h02, 0, z, z, 0,    5'h1F, 5'h00, 5'h00, 5'h1F, 0);
        add(0, 5'h10, 5'h00, 0, z, z, 0,    5'h0F, 5'h00, 5'h00, 5'h1F, 0);
        add(0, 5'h00, 5'h00, 1, a2, z0, 0,  5'h0F, 5'h00, 5'h00, 5'h1F, 1);
        add(0, 5'h10, 5'h00, 0, z, z, 0,    5'h0F, 5'h00, 5'h00, 5'h0F, 1);
        add(0, 5'h00, 5'h10, 0, z, z, 0,    5'h0F, 5'h00, 5'h00, 5'h1F, 1);
        add(0, 5'h00, 5'h10, 0, z, z, 0,    5'h1F, 5'h00, 5'h00, 5'h1F, 1);
        add(0, 5'h00, 5'h00, 1, a2, z0, 0,  5'h1F, 5'h00, 5'h00, 5'h1F, 1);
        add(0, 5'h00, 5'h00, 0, z, z, 1,    5'h1F, 5'h00, 5'h00, 5'h1F, 0);
        add(0, 5'h10, 5'h00, 0, z, z, 0,    5'h0F, 5'h00, 5'h00, 5'h0F, 0);
        add(0, 5'h10, 5'h00, 0, z, z, 0,    5'h0F, 5'h00, 5'h10, 5'h0F, 0);
        add(0, 5'h00, 5'h10, 0, z, z, 0,    5'h0F, 5'h00, 5'h00, 5'h0F, 0);
        add(0, 5'h00, 5'h10, 0, z, z, 0,    5'h1F, 5'h00, 5'h00, 5'h1F, 0);
        add(0, 5'h01, 5'h00, 1, z, rep(4), 0, 5'h1E, 5'h00, 5'h00, 5'h1E, 1);
        add(0, 5'h00, 5'h01, 0, z, z, 1,    5'h1F, 5'h00, 5'h00, 5'h1F, 0);
        add(0, 5'h01, 5'h00, 0, z, z, 0,    5'h1E, 5'h00, 5'h00, 5'h1E, 0);
        add(1, 5'h1F, 5'h1F, 0, z, z, 0,    5'h1F, 5'h00, 5'h00, 5'h1F, 0);
        add(0, 5'h01, 5'h00, 0, z, z, 0,    5'h1E, 5'h00, 5'h00, 5'h1F, 0);

        foreach (vecs[n]) begin
            drive(vecs[n].rst, vecs[n].psh, vecs[n].pp, vecs[n].ld, vecs[n].af, vecs[n].ae, vecs[n].clr);
            chk("empties", n, FIFO_empties, vecs[n].e_emp);
            chk("errors", n, FIFO_errors, vecs[n].e_err);
            chk("almost_full", n, almost_full, vecs[n].e_af);
            chk("almost_empty", n, almost_empty, vecs[n].e_ae);
            chk("all_empty", n, {4'b0, all_empty}, {4'b0, vecs[n].e_emp == 5'h1F});
            chk("cfg_err", n, {4'b0, cfg_err}, {4'b0, vecs[n].e_cerr});
        end

        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic        r_rst, r_ld, r_clr;
            logic [4:0]  r_psh, r_pp;
            logic [14:0] r_af, r_ae;
            bit          drain;
            drain = ((cyc / 50) % 4) == 3;
            r_rst = (cyc == 0) || (cyc == 1000);
            r_psh = drain ? 5'h00 : 5'($urandom);
            r_pp  = drain ? 5'($urandom | $urandom) : 5'($urandom);
            r_ld  = drain ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            r_af  = 15'($urandom);
            r_ae  = 15'($urandom);
            r_clr = ($urandom_range(0, 31) == 0);
            drive(r_rst, r_psh, r_pp, r_ld, r_af, r_ae, r_clr);
            model_step(r_rst, r_psh, r_pp, r_ld, r_af, r_ae, r_clr);
            for (int i = 0; i < NF; i++) begin
                e_emp[i] = (m_cnt[i] == 0);
                e_af[i]  = (m_af[i] != 0) && (m_cnt[i] >= m_af[i]);
                e_ae[i]  = (m_cnt[i] <= m_ae[i]);
            end
            chk("rnd_empties", cyc, FIFO_empties, e_emp);
            chk("rnd_errors", cyc, FIFO_errors, m_err);
            chk("rnd_almost_full", cyc, almost_full, e_af);
            chk("rnd_almost_empty", cyc, almost_empty, e_ae);
            chk("rnd_all_empty", cyc, {4'b0, all_empty}, {4'b0, e_emp == 5'h1F});
            chk("rnd_cfg_err", cyc, {4'b0, cfg_err}, {4'b0, m_cerr});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
